// File: rtl/cb_vm_agd_pkg.sv
// Shared widths for the covariance-bank address path, used by the CB memory,
// the vm sequencer and the base-address generator.
package cb_vm_agd_pkg;

    localparam int CB_AW_DEF   = 17;
    localparam int ROW_LEN_DEF = 10;
    localparam int PROD_W_DEF  = 2 * ROW_LEN_DEF + 1;

    // Reference triangular number g*(g+1)/2 at the default widths, modulo 2^CB_AW.
    function automatic logic [CB_AW_DEF-1:0] tri_num(input logic [ROW_LEN_DEF-1:0] g);
        logic [PROD_W_DEF-1:0] p;
        p = PROD_W_DEF'(g) * (PROD_W_DEF'(g) + PROD_W_DEF'(1'b1));
        return CB_AW_DEF'(p >> 1);
    endfunction

endpackage

// File: rtl/cb_vm_agd_mul.sv
// Combinational shift-add multiplier producing g*(g+1) at full width.
module cb_vm_agd_mul
    import cb_vm_agd_pkg::*;
#(
    parameter int ROW_LEN = ROW_LEN_DEF
) (
    input  logic [ROW_LEN-1:0]   g,
    output logic [2*ROW_LEN:0]   prod
);

    localparam int PW = 2 * ROW_LEN + 1;

    logic [ROW_LEN:0] g_inc_s;
    logic [PW-1:0]    acc_s;

    assign g_inc_s = {1'b0, g} + {{ROW_LEN{1'b0}}, 1'b1};

    // Accumulate g shifted by each set bit of g+1; the sum cannot exceed PW bits.
    always_comb begin
        acc_s = {PW{1'b0}};
        for (int i = 0; i <= ROW_LEN; i++) begin
            if (g_inc_s[i]) begin
                acc_s = acc_s + (PW'(g) << i);
            end else begin
                acc_s = acc_s;
            end
        end
    end

    assign prod = acc_s;

endmodule

// File: rtl/cb_vm_agd.sv
// Base-address generator for a group's row in lower-triangular covariance
// storage: CB_base_addr = g*(g+1)/2 mod 2^CB_AW, two enabled pipeline stages.
module cb_vm_agd
    import cb_vm_agd_pkg::*;
#(
    parameter int CB_AW   = CB_AW_DEF,
    parameter int ROW_LEN = ROW_LEN_DEF
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic               en,
    input  logic [ROW_LEN-1:0] group_cnt,
    output logic [CB_AW-1:0]   CB_base_addr
);

    localparam int PW = 2 * ROW_LEN + 1;

    logic [PW-1:0] prod_s;
    logic [PW-1:0] prod_r;
    logic [PW-1:0] half_s;

    cb_vm_agd_mul #(
        .ROW_LEN (ROW_LEN)
    ) u_mul (
        .g    (group_cnt),
        .prod (prod_s)
    );

    // Product of consecutive integers is even, so the shift divides exactly.
    assign half_s = prod_r >> 1;

    // Stage 1: capture the full-width product.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            prod_r <= {PW{1'b0}};
        end else if (en) begin
            prod_r <= prod_s;
        end else begin
            prod_r <= prod_r;
        end
    end

    // Stage 2: halve and wrap to the CB address width.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            CB_base_addr <= {CB_AW{1'b0}};
        end else if (en) begin
            CB_base_addr <= CB_AW'(half_s);
        end else begin
            CB_base_addr <= CB_base_addr;
        end
    end

endmodule

// File: tb/tb_cb_vm_agd.sv
// Directed bench for cb_vm_agd: reset, sweep, latency, wrap, streaming, hold.
module tb_cb_vm_agd;

    logic        clk;
    logic        sys_rst;
    logic        en;
    logic [9:0]  group_cnt;
    logic [16:0] CB_base_addr;

    int checks   = 0;
    int failures = 0;

    cb_vm_agd dut (
        .clk          (clk),
        .sys_rst      (sys_rst),
        .en           (en),
        .group_cnt    (group_cnt),
        .CB_base_addr (CB_base_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expect_addr(input int g);
        return 32'((g * (g + 1) / 2) % 131072);
    endfunction

    task automatic pulse(input int g);
        group_cnt = 10'(g);
        en = 1'b1;
        tick();
        tick();
        en = 1'b0;
    endtask

    initial begin
        sys_rst   = 1'b1;
        en        = 1'b0;
        group_cnt = 10'd0;
        tick();
        tick();
        check("reset_idle", 32'(CB_base_addr), 32'd0);

        // Enable under reset must not load anything.
        group_cnt = 10'd5;
        en = 1'b1;
        tick();
        check("reset_en_1", 32'(CB_base_addr), 32'd0);
        tick();
        check("reset_en_2", 32'(CB_base_addr), 32'd0);
        sys_rst = 1'b0;
        en = 1'b0;
        tick();
        check("reset_release", 32'(CB_base_addr), 32'd0);

        // Sweep g=0..31 with a hold of three cycles after each pulse.
        for (int g = 0; g < 32; g++) begin
            pulse(g);
            check($sformatf("sweep_g%0d", g), 32'(CB_base_addr), expect_addr(g));
            for (int h = 0; h < 3; h++) begin
                tick();
                check($sformatf("sweep_hold_g%0d", g), 32'(CB_base_addr), expect_addr(g));
            end
        end
        check("sweep_g5_const", expect_addr(5), 32'd15);

        // One enabled edge leaves the stale previous result (496 from g=31).
        group_cnt = 10'd10;
        en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        check("latency_stale", 32'(CB_base_addr), 32'd496);
        en = 1'b1;
        tick();
        en = 1'b0;
        check("latency_second", 32'(CB_base_addr), 32'd55);

        // Width limits.
        pulse(511);
        check("width_511", 32'(CB_base_addr), 32'd130816);
        pulse(512);
        check("width_512", 32'(CB_base_addr), 32'd256);
        pulse(1023);
        check("width_1023", 32'(CB_base_addr), 32'd130560);

        // Continuous enable: output lags group_cnt by two edges.
        en = 1'b1;
        group_cnt = 10'd3;
        tick();
        check("stream_prev", 32'(CB_base_addr), 32'd130560);
        group_cnt = 10'd4;
        tick();
        check("stream_3", 32'(CB_base_addr), 32'd6);
        group_cnt = 10'd7;
        tick();
        check("stream_4", 32'(CB_base_addr), 32'd10);
        tick();
        check("stream_7", 32'(CB_base_addr), 32'd28);

        // Hold with en low while the index wanders.
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            group_cnt = 10'($urandom_range(1023, 0));
            tick();
            check("hold_random", 32'(CB_base_addr), 32'd28);
        end

        // Reset mid-computation discards the pending stage-1 value.
        group_cnt = 10'd20;
        en = 1'b1;
        tick();
        sys_rst = 1'b1;
        tick();
        check("midrst_out", 32'(CB_base_addr), 32'd0);
        sys_rst = 1'b0;
        en = 1'b0;
        tick();
        check("midrst_hold", 32'(CB_base_addr), 32'd0);
        en = 1'b1;
        tick();
        en = 1'b0;
        check("midrst_discard", 32'(CB_base_addr), 32'd0);
        tick();
        en = 1'b1;
        tick();
        en = 1'b0;
        check("midrst_recover", 32'(CB_base_addr), 32'd210);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
